// File: rtl/pong_pkg.sv
// Shared constants for the pong game controller.
// State codes, lives default and BCD helpers.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_MISS_WAIT = 3'd4,
    ST_OVER      = 3'd5
  } state_e;

  localparam int         LIVES_INIT_DEF = 3;
  localparam logic [7:0] BCD_MAX        = 8'h99;
  localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [7:0] BCD_ZERO       = 8'h00;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v
  );
    logic [7:0] r;
    if (v == BCD_MAX) begin
      r = v;
    end else if (v[3:0] == BCD_DIGIT_MAX) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Valid BCD orders the same as plain binary.
  function automatic logic bcd_gt(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return a > b;
  endfunction

endpackage

// File: rtl/game_ctrl_fsm_bcd2_counter.sv
// Two-digit saturating BCD incrementer with
// synchronous clear.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = BCD_ZERO;
    end else if (inc) begin
      q_d = bcd_inc(q_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Pong game controller: serve, play, pause,
// miss handling, lives and score keeping.
module game_ctrl_fsm
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 30,
  parameter int LIVES_INIT   = LIVES_INIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       hit,
  input  logic       miss,
  output logic       game_en,
  output logic       engine_hold,
  output logic [2:0] state,
  output logic [7:0] score_bcd,
  output logic [7:0] hiscore_bcd,
  output logic [2:0] lives,
  output logic       game_over
);

  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] PAUSE_N = 8'(PAUSE_FRAMES);
  localparam logic [2:0] LIVES_N = 3'(LIVES_INIT);

  logic [1:0] rst_sync_q;
  logic [1:0] rst_sync_d;
  logic       run_ok;

  logic [3:0] in_s_q;
  logic [3:0] in_s_d;
  logic [3:0] in_p_q;
  logic [3:0] in_p_d;
  logic [3:0] ev;
  logic       ev_start;
  logic       ev_pause;
  logic       ev_hit;
  logic       ev_miss;

  state_e     state_q;
  state_e     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic [2:0] lives_q;
  logic [2:0] lives_d;
  logic [7:0] hiscore_q;
  logic [7:0] hiscore_d;
  logic       score_clr;
  logic       score_inc;
  logic [7:0] score;

  // Release of reset only takes effect two edges later.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    in_s_d     = {start, pause, hit, miss};
    in_p_d     = in_s_q;
  end

  assign run_ok   = rst_sync_q[1];
  assign ev       = in_s_q & ~in_p_q;
  assign ev_start = ev[3];
  assign ev_pause = ev[2];
  assign ev_hit   = ev[1];
  assign ev_miss  = ev[0];
  assign cnt_inc  = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lives_d   = lives_q;
    hiscore_d = hiscore_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev_start && run_ok) begin
          state_d   = ST_SERVE;
          score_clr = 1'b1;
          lives_d   = LIVES_N;
          cnt_d     = 8'd0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_inc == SERVE_N) begin
            state_d = ST_PLAY;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_PLAY: begin
        if (ev_miss) begin
          lives_d = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_d = ST_OVER;
            if (bcd_gt(score, hiscore_q)) begin
              hiscore_d = score;
            end
          end else begin
            state_d = ST_MISS_WAIT;
            cnt_d   = 8'd0;
          end
        end else begin
          score_inc = ev_hit;
          if (ev_pause) begin
            state_d = ST_PAUSED;
          end
        end
      end
      ST_PAUSED: begin
        if (ev_pause) begin
          state_d = ST_PLAY;
        end
      end
      ST_MISS_WAIT: begin
        if (frame_tick) begin
          if (cnt_inc == PAUSE_N) begin
            state_d = ST_SERVE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_OVER: begin
        if (ev_start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
      in_s_q     <= 4'd0;
      in_p_q     <= 4'd0;
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      lives_q    <= LIVES_N;
      hiscore_q  <= BCD_ZERO;
    end else begin
      rst_sync_q <= rst_sync_d;
      in_s_q     <= in_s_d;
      in_p_q     <= in_p_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lives_q    <= lives_d;
      hiscore_q  <= hiscore_d;
    end
  end

  bcd2_counter u_score (
    .clk (clk),
    .rst (rst),
    .clr (score_clr),
    .inc (score_inc),
    .q   (score)
  );

  assign state       = state_q;
  assign score_bcd   = score;
  assign hiscore_bcd = hiscore_q;
  assign lives       = lives_q;
  assign game_en     = (state_q == ST_PLAY);
  assign engine_hold = (state_q != ST_PLAY) &&
                       (state_q != ST_PAUSED);
  assign game_over   = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Scoreboard bench for game_ctrl_fsm.
// Expectations queued with stimulus, drained on output.
module tb_game_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       game_en;
  logic       engine_hold;
  logic [2:0] state;
  logic [7:0] score_bcd;
  logic [7:0] hiscore_bcd;
  logic [2:0] lives;
  logic       game_over;

  localparam int S_ST  = 0;
  localparam int S_SC  = 1;
  localparam int S_HI  = 2;
  localparam int S_LV  = 3;
  localparam int S_EN  = 4;
  localparam int S_HD  = 5;
  localparam int S_GO  = 6;

  localparam int P_START = 0;
  localparam int P_PAUSE = 1;
  localparam int P_HIT   = 2;
  localparam int P_MISS  = 3;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  game_ctrl_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .pause       (pause),
    .hit         (hit),
    .miss        (miss),
    .game_en     (game_en),
    .engine_hold (engine_hold),
    .state       (state),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .lives       (lives),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    logic [7:0] v;
    case (sel)
      S_ST:    v = {5'd0, state};
      S_SC:    v = score_bcd;
      S_HI:    v = hiscore_bcd;
      S_LV:    v = {5'd0, lives};
      S_EN:    v = {7'd0, game_en};
      S_HD:    v = {7'd0, engine_hold};
      S_GO:    v = {7'd0, game_over};
      default: v = 8'hxx;
    endcase
    return v;
  endfunction

  task automatic exp_out(
    input string      tag,
    input int         sel,
    input logic [7:0] exp
  );
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain_now();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    drain_now();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      step(1);
    end
  endtask

  task automatic drive(input int which, input logic v);
    case (which)
      P_START: start = v;
      P_PAUSE: pause = v;
      P_HIT:   hit   = v;
      default: miss  = v;
    endcase
  endtask

  task automatic pulse(input int which);
    drive(which, 1'b1);
    step(2);
    drive(which, 1'b0);
    step(3);
  endtask

  task automatic pulses(input int which, input int n);
    repeat (n) pulse(which);
  endtask

  task automatic exp_mode(
    input string      tag,
    input logic [2:0] st,
    input logic       en,
    input logic       hd
  );
    exp_out({tag, "_state"}, S_ST, {5'd0, st});
    exp_out({tag, "_en"}, S_EN, {7'd0, en});
    exp_out({tag, "_hold"}, S_HD, {7'd0, hd});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    exp_mode("rst", 3'd0, 1'b0, 1'b1);
    exp_out("rst_score", S_SC, 8'h00);
    exp_out("rst_hi", S_HI, 8'h00);
    exp_out("rst_lives", S_LV, 8'd3);
    exp_out("rst_over", S_GO, 8'd0);
    drain();
    rst = 1'b1;
    step(4);

    pulse(P_START);
    exp_mode("serve", 3'd1, 1'b0, 1'b1);
    exp_out("serve_lives", S_LV, 8'd3);
    exp_out("serve_score", S_SC, 8'h00);
    drain();
    ticks(59);
    exp_mode("serve59", 3'd1, 1'b0, 1'b1);
    drain();
    ticks(1);
    exp_mode("play", 3'd2, 1'b1, 1'b0);
    exp_out("play_lives", S_LV, 8'd3);
    drain();

    hit = 1'b1;
    ticks(5);
    hit = 1'b0;
    step(3);
    exp_out("hit_held", S_SC, 8'h01);
    drain();
    pulses(P_HIT, 8);
    exp_out("hit_09", S_SC, 8'h09);
    drain();
    pulses(P_HIT, 1);
    exp_out("hit_10", S_SC, 8'h10);
    drain();
    pulses(P_HIT, 2);
    exp_out("hit_12", S_SC, 8'h12);
    drain();
    pulses(P_HIT, 87);
    exp_out("hit_99", S_SC, 8'h99);
    drain();
    pulses(P_HIT, 1);
    exp_out("hit_sat", S_SC, 8'h99);
    drain();

    pulse(P_PAUSE);
    exp_mode("paused", 3'd3, 1'b0, 1'b0);
    drain();
    pulse(P_MISS);
    exp_out("paused_miss_lv", S_LV, 8'd3);
    exp_out("paused_miss_st", S_ST, 8'd3);
    drain();
    pulse(P_PAUSE);
    exp_mode("resume", 3'd2, 1'b1, 1'b0);
    drain();

    hit  = 1'b1;
    miss = 1'b1;
    step(2);
    hit  = 1'b0;
    miss = 1'b0;
    step(3);
    exp_mode("hitmiss", 3'd4, 1'b0, 1'b1);
    exp_out("hitmiss_lv", S_LV, 8'd2);
    exp_out("hitmiss_sc", S_SC, 8'h99);
    drain();
    ticks(29);
    exp_out("wait29", S_ST, 8'd4);
    drain();
    ticks(1);
    exp_out("wait30", S_ST, 8'd1);
    drain();
    ticks(60);
    exp_out("play2", S_ST, 8'd2);
    drain();

    pulse(P_MISS);
    exp_out("miss2_st", S_ST, 8'd4);
    exp_out("miss2_lv", S_LV, 8'd1);
    drain();
    ticks(30);
    ticks(60);
    exp_out("play3", S_ST, 8'd2);
    drain();
    pulse(P_MISS);
    exp_mode("over", 3'd5, 1'b0, 1'b1);
    exp_out("over_lv", S_LV, 8'd0);
    exp_out("over_go", S_GO, 8'd1);
    exp_out("over_hi", S_HI, 8'h99);
    drain();

    pulse(P_START);
    exp_out("idle_st", S_ST, 8'd0);
    exp_out("idle_go", S_GO, 8'd0);
    exp_out("idle_hi", S_HI, 8'h99);
    drain();
    pulse(P_START);
    exp_out("g2_st", S_ST, 8'd1);
    exp_out("g2_sc", S_SC, 8'h00);
    exp_out("g2_lv", S_LV, 8'd3);
    drain();
    ticks(60);
    pulse(P_HIT);
    pulse(P_MISS);
    exp_out("g2_wait", S_ST, 8'd4);
    exp_out("g2_sc1", S_SC, 8'h01);
    drain();

    step(1);
    #2;
    rst = 1'b0;
    #1;
    exp_mode("arst", 3'd0, 1'b0, 1'b1);
    exp_out("arst_sc", S_SC, 8'h00);
    exp_out("arst_hi", S_HI, 8'h00);
    exp_out("arst_lv", S_LV, 8'd3);
    exp_out("arst_go", S_GO, 8'd0);
    drain_now();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl_fsm.md
GAME_CTRL_FSM -- requirements
Module: game_ctrl_fsm

Interface
REQ-001 Parameter SERVE_FRAMES, default 60, frames the ball is held at the serve position before play.
REQ-002 Parameter PAUSE_FRAMES, default 30, frames of freeze after a miss.
REQ-003 Parameter LIVES_INIT, default 3, lives at game start (range 1..7).
REQ-004 clk  in  1  single system clock; all flops on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset (low = reset asserted).
REQ-006 frame_tick  in  1  one-clk pulse per video frame (end of active area).
REQ-007 start  in  1  start button, debounced level.
REQ-008 pause  in  1  pause button, debounced level.
REQ-009 hit  in  1  paddle-contact level from game engine.
REQ-010 miss  in  1  ball-out level from game engine.
REQ-011 game_en  out  1  engine position-update enable.
REQ-012 engine_hold  out  1  forces engine to serve position (bar centred, ball centred).
REQ-013 state  out  3  current state encoding.
REQ-014 score_bcd  out  8  current score, two BCD digits.
REQ-015 hiscore_bcd  out  8  best score since reset, two BCD digits.
REQ-016 lives  out  3  remaining lives.
REQ-017 game_over  out  1  high in OVER state.

Function
REQ-018 start, pause, hit, miss SHALL each pass one sync flop (s) and one history flop (p); event = s & ~p (rising edge only), so a held level yields one event.
REQ-019 States SHALL be IDLE=0, SERVE=1, PLAY=2, PAUSED=3, MISS_WAIT=4, OVER=5; codes 6-7 SHALL return to IDLE next clk.
REQ-020 IDLE: game_en=0, engine_hold=1; start event -> SERVE, same edge loads score=00, lives=LIVES_INIT, frame counter=0.
REQ-021 SERVE: game_en=0, engine_hold=1; counter increments per frame_tick; on the frame_tick that makes counter = SERVE_FRAMES -> PLAY, counter cleared.
REQ-022 PLAY: game_en=1, engine_hold=0; hit event increments score in BCD (09->10, 99 saturates at 99).
REQ-023 PLAY miss event: lives decremented; if lives was 1 -> OVER, else -> MISS_WAIT with counter cleared.
REQ-024 Simultaneous hit and miss events in PLAY: miss SHALL win, score unchanged.
REQ-025 PLAY pause event -> PAUSED; PAUSED: game_en=0, engine_hold=0, hit/miss ignored; pause event -> PLAY.
REQ-026 Simultaneous pause and miss events in PLAY: miss SHALL win.
REQ-027 MISS_WAIT: game_en=0, engine_hold=1; after PAUSE_FRAMES frame_ticks -> SERVE, counter cleared.
REQ-028 OVER: game_en=0, engine_hold=1, game_over=1; on entry hiscore_bcd loads score_bcd if score_bcd > hiscore_bcd (BCD compare equals binary compare); start event -> IDLE.
REQ-029 hit/miss events outside PLAY SHALL have no effect; start events outside IDLE/OVER ignored.
REQ-030 Frame counter 8 bits; SERVE_FRAMES, PAUSE_FRAMES SHALL be 1..255.
REQ-031 Latency: input rise at edge N sampled to s at N+1, event at N+1..N+2, registered outputs update at edge N+2.
REQ-032 All outputs SHALL be registered or decoded solely from registered state.

Reset
REQ-033 rst low SHALL immediately force state=IDLE, score_bcd=00, hiscore_bcd=00, lives=LIVES_INIT, counter=0, sync/history flops=0.
REQ-034 During reset: game_en=0, engine_hold=1, game_over=0; reset mid-PLAY discards score and hiscore.
REQ-035 rst deassertion SHALL be synchronised (two flops) before state may leave IDLE.

Structure
REQ-036 State codes, LIVES_INIT default and BCD increment/compare constants SHALL live in shared package pong_pkg.
REQ-037 One sub-module bcd2_counter (2-digit saturating BCD incrementer with clear) SHALL be instantiated for score.

Verification
REQ-038 Reset, start pulse, 60 frame_ticks -> state SERVE->PLAY on 60th tick, game_en=1, lives=3.
REQ-039 In PLAY, hit held 5 frames then 11 more pulses -> score_bcd=0x12 (one count per rise).
REQ-040 score 0x99, further hit -> score stays 0x99; 0x09 + hit -> 0x10.
REQ-041 Three misses with 30-frame waits -> lives 3,2,1,0, OVER, game_over=1, hiscore_bcd=score.
REQ-042 hit and miss rise same clk -> lives-1, score unchanged; pause in PLAY -> PAUSED, misses ignored, pause -> PLAY.
REQ-043 rst low mid-MISS_WAIT -> outputs at reset values asynchronously, before next clk edge.
